// File: rtl/sr_muldiv_if.sv
// sr_muldiv_if: request/response bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//   req_valid/req_ready  request handshake, oper/srcA/srcB sampled on accept
//   kill                 pipeline flush, aborts whatever the unit is doing
//   resp_valid/resp_ready response handshake, result held until consumed
//   busy                 unit not idle (core stall)
// master = core side, slave = the unit.
interface sr_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       oper;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output req_valid, oper, srcA, srcB, kill, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, oper, srcA, srcB, kill, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/sr_muldiv.sv
// sr_muldiv: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, sign fix applied on the last iteration.
// Ports:
//   clk  core clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  sr_muldiv_if.slave: req_valid/req_ready, oper (funct3), srcA, srcB,
//        kill, resp_valid/resp_ready, result (registered), busy
// Latency: accept in cycle 0, resp_valid from cycle WIDTH+1; divide-by-zero
// and signed-overflow divides answer in cycle 1.
module sr_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  sr_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             neg;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi, lo, mb;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Request decode: sign handling, magnitudes, special cases
  logic signed [WIDTH-1:0] a_s, b_s;
  logic             a_sgn_op, b_sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div0, ovf, special, accept, last;
  logic [WIDTH-1:0] spec_res;

  assign a_s = bus.srcA;
  assign b_s = bus.srcB;

  always_comb begin
    a_sgn_op = (bus.oper == 3'd1) || (bus.oper == 3'd2) ||
               (bus.oper == 3'd4) || (bus.oper == 3'd6);
    b_sgn_op = (bus.oper == 3'd1) || (bus.oper == 3'd4) || (bus.oper == 3'd6);
    a_neg    = a_sgn_op && (a_s < 0);
    b_neg    = b_sgn_op && (b_s < 0);
    mag_a    = cond_neg_w(bus.srcA, a_neg);
    mag_b    = cond_neg_w(bus.srcB, b_neg);
    div0     = bus.oper[2] && (bus.srcB == '0);
    ovf      = ((bus.oper == 3'd4) || (bus.oper == 3'd6)) &&
               (bus.srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.srcB == '1);
    special  = div0 || ovf;
    if (div0) spec_res = bus.oper[1] ? bus.srcA : '1;
    else      spec_res = bus.oper[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  assign accept = bus.req_valid && (state == IDLE) && !bus.kill;
  assign last   = (state == CALC) && (cnt == CW'(1));

  // One iteration step: multiply keeps {hi,lo} as a right-shifting product,
  // divide keeps remainder in hi and shifts the quotient into lo.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   it_hi, it_lo, fin;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, mb};
    if (op[2]) begin
      it_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      it_lo = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod_fix = cond_neg_2w({it_hi, it_lo}, neg);
    if (op[2])               fin = op[1] ? cond_neg_w(it_hi, neg) : cond_neg_w(it_lo, neg);
    else if (op[1:0] == 2'd0) fin = prod_fix[WIDTH-1:0];
    else                      fin = prod_fix[2*WIDTH-1:WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; kill overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;
  end

  // FSM outputs
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.resp_valid = (state == DONE);
  end

  assign bus.result = result_q;

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op       <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else if (bus.kill) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CW'(WIDTH);
      op  <= bus.oper;
      // Remainder follows the dividend; quotient and product follow sign xor.
      neg <= (bus.oper[2] && bus.oper[1]) ? a_neg : (a_neg ^ b_neg);
      if (special) result_q <= spec_res;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (last) result_q <= fin;
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      hi <= '0;
      lo <= mag_a;
      mb <= mag_b;
    end else if (state == CALC) begin
      hi <= it_hi;
      lo <= it_lo;
    end
  end
endmodule
